// File: rtl/mips_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_pkg : state, opcode and select encodings for the multicycle MIPS control
// Revision : 1.0
// ---------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [3:0] {
    RESET   = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    RTYPEEX = 4'd7,
    RTYPEWB = 4'd8,
    BEQEX   = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    JEX     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_outdec.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_outdec : Moore control-word decode from the main-control state
// Revision  : 1.0
// ---------------------------------------------------------------------------
module mc_outdec
  import mips_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.pcsrc   = PCSRC_ALU;
        ctrl.aluop   = ALUOP_ADD;
      end
      DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.aluop   = ALUOP_ADD;
      end
      MEMADR, ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_req  = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_RT;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_RT;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
      ADDIWB:  ctrl.regwrite = 1'b1;
      JEX: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_main_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_main_ctrl : multicycle MIPS main-control FSM with memory-ready handshake
// Revision     : 1.0
// ---------------------------------------------------------------------------
module mc_main_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       pcen,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] aluop,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state_o
);

  localparam int            CW   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state, next_state;
  logic [CW-1:0] wait_cnt;
  logic          stalled, timeout, illegal;
  ctrl_t         ctrl;

  assign stalled = is_mem_state(state) && !mem_ready;
  assign timeout = (MEM_TIMEOUT != 0) && stalled && (wait_cnt == LAST);

  always_comb begin
    next_state = state;
    illegal    = 1'b0;
    case (state)
      RESET:   next_state = FETCH;
      FETCH:   if (mem_ready) next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = RTYPEEX;
          OP_BEQ:       next_state = BEQEX;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JEX;
          default: begin
            next_state = FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      MEMADR:  next_state = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD: begin
        if (mem_ready)    next_state = MEMWB;
        else if (timeout) next_state = FETCH;
      end
      MEMWR:   if (mem_ready || timeout) next_state = FETCH;
      RTYPEEX: next_state = RTYPEWB;
      ADDIEX:  next_state = ADDIWB;
      default: next_state = FETCH;
    endcase
  end

  // Counter only survives a stalled cycle that stays put; any entry, completion or timeout clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RESET;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (stalled && !timeout && (MEM_TIMEOUT != 0)) wait_cnt <= wait_cnt + 1'b1;
      else                                            wait_cnt <= '0;
    end
  end

  mc_outdec u_outdec (
    .state (state),
    .ctrl  (ctrl)
  );

  assign mem_req    = ctrl.mem_req;
  assign memwrite   = ctrl.memwrite;
  assign irwrite    = ctrl.irwrite & mem_ready;
  // Only FETCH carries both pcwrite and mem_req, so its PC update waits for the memory.
  assign pcen       = (ctrl.pcwrite & (mem_ready | ~ctrl.mem_req)) | (ctrl.branch & zero);
  assign regwrite   = ctrl.regwrite;
  assign iord       = ctrl.iord;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign pcsrc      = ctrl.pcsrc;
  assign regdst     = ctrl.regdst;
  assign memtoreg   = ctrl.memtoreg;
  assign aluop      = ctrl.aluop;
  assign illegal_op = illegal;
  assign bus_err    = timeout;
  assign state_o    = state;

endmodule
`default_nettype wire

// File: tb/tb_mc_main_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mc_main_ctrl : scoreboard bench for the multicycle main-control FSM
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_mc_main_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, memwrite, irwrite, regwrite, pcen, iord, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       regdst, memtoreg, illegal_op, bus_err;
  logic [3:0] state_o;

  mc_main_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .pcen(pcen), .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .regdst(regdst), .memtoreg(memtoreg), .aluop(aluop), .illegal_op(illegal_op),
    .bus_err(bus_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, memwrite, irwrite, regwrite, pcen, iord, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       regdst, memtoreg;
    logic [1:0] aluop;
    logic       illegal_op, bus_err;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  e;
  } sb_t;

  localparam int S_RESET = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMRD = 4,
                 S_MEMWB = 5, S_MEMWR = 6, S_RTYPEEX = 7, S_RTYPEWB = 8, S_BEQEX = 9,
                 S_ADDIEX = 10, S_ADDIWB = 11, S_JEX = 12;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

  obs_t got;
  assign got = {state_o, mem_req, memwrite, irwrite, regwrite, pcen, iord, alusrca,
                alusrcb, pcsrc, regdst, memtoreg, aluop, illegal_op, bus_err};

  int  checks = 0;
  int  errors = 0;
  sb_t sb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, obs, exp);
    end
  endtask

  // Expected Moore control word of each state, straight from the state table.
  function automatic obs_t exp_st(input int s);
    obs_t e;
    e    = '0;
    e.st = 4'(s);
    case (s)
      S_FETCH:   begin e.mem_req = 1; e.alusrcb = 2'b01; end
      S_DECODE:  e.alusrcb = 2'b11;
      S_MEMADR:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      S_MEMRD:   begin e.mem_req = 1; e.iord = 1; end
      S_MEMWB:   begin e.regwrite = 1; e.memtoreg = 1; end
      S_MEMWR:   begin e.mem_req = 1; e.iord = 1; e.memwrite = 1; end
      S_RTYPEEX: begin e.alusrca = 1; e.aluop = 2'b10; end
      S_RTYPEWB: begin e.regwrite = 1; e.regdst = 1; end
      S_BEQEX:   begin e.alusrca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01; end
      S_ADDIEX:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      S_ADDIWB:  e.regwrite = 1;
      S_JEX:     begin e.pcsrc = 2'b10; e.pcen = 1; end
      default:   e = '0;
    endcase
    return e;
  endfunction

  function automatic obs_t exp_fetch(input logic rdy, input logic err);
    obs_t e;
    e         = exp_st(S_FETCH);
    e.irwrite = rdy;
    e.pcen    = rdy;
    e.bus_err = err;
    return e;
  endfunction

  function automatic obs_t with_flags(input obs_t base, input logic pc, input logic ill,
                                      input logic err);
    obs_t e;
    e            = base;
    e.pcen       = e.pcen | pc;
    e.illegal_op = ill;
    e.bus_err    = err;
    return e;
  endfunction

  // Drive one cycle of stimulus and queue what the DUT must show this cycle.
  task automatic cyc(input string tag, input logic [5:0] o, input logic rdy, input logic z,
                     input obs_t e);
    sb_t it;
    op        = o;
    mem_ready = rdy;
    zero      = z;
    it.tag    = tag;
    it.e      = e;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      sb_t it;
      it = sb_q.pop_front();
      check_eq(it.tag, 32'(got), 32'(it.e));
    end
  end

  initial begin
    @(posedge clk);
    #1;
    cyc("rst_hold", RT, 0, 0, exp_st(S_RESET));
    reset_n = 1'b1;
    cyc("rst_release", RT, 1, 0, exp_st(S_RESET));

    cyc("lw_fetch",  LW, 1, 0, exp_fetch(1, 0));
    cyc("lw_decode", LW, 1, 0, exp_st(S_DECODE));
    cyc("lw_memadr", LW, 1, 0, exp_st(S_MEMADR));
    cyc("lw_memrd",  LW, 1, 0, exp_st(S_MEMRD));
    cyc("lw_memwb",  LW, 1, 0, exp_st(S_MEMWB));

    cyc("rt_fetch",  RT, 1, 0, exp_fetch(1, 0));
    cyc("rt_decode", RT, 0, 0, exp_st(S_DECODE));
    cyc("rt_ex",     RT, 0, 0, exp_st(S_RTYPEEX));
    cyc("rt_wb",     RT, 1, 0, exp_st(S_RTYPEWB));

    cyc("beq1_fetch",  BEQ, 1, 0, exp_fetch(1, 0));
    cyc("beq1_decode", BEQ, 1, 1, exp_st(S_DECODE));
    cyc("beq1_ex",     BEQ, 1, 1, with_flags(exp_st(S_BEQEX), 1, 0, 0));
    cyc("beq0_fetch",  BEQ, 1, 1, exp_fetch(1, 0));
    cyc("beq0_decode", BEQ, 1, 0, exp_st(S_DECODE));
    cyc("beq0_ex",     BEQ, 1, 0, exp_st(S_BEQEX));

    cyc("addi_fetch",  ADDI, 1, 0, exp_fetch(1, 0));
    cyc("addi_decode", ADDI, 1, 0, exp_st(S_DECODE));
    cyc("addi_ex",     ADDI, 1, 0, exp_st(S_ADDIEX));
    cyc("addi_wb",     ADDI, 1, 0, exp_st(S_ADDIWB));

    cyc("j_fetch",  JMP, 1, 0, exp_fetch(1, 0));
    cyc("j_decode", JMP, 1, 0, exp_st(S_DECODE));
    cyc("j_ex",     JMP, 1, 0, exp_st(S_JEX));

    cyc("ill_fetch",  BAD, 1, 0, exp_fetch(1, 0));
    cyc("ill_decode", BAD, 1, 0, with_flags(exp_st(S_DECODE), 0, 1, 0));

    cyc("sw_fetch",  SW, 1, 0, exp_fetch(1, 0));
    cyc("sw_decode", SW, 1, 0, exp_st(S_DECODE));
    cyc("sw_memadr", SW, 1, 0, exp_st(S_MEMADR));
    for (int i = 0; i < 3; i++) cyc("sw_stall", SW, 0, 0, exp_st(S_MEMWR));
    cyc("sw_done", SW, 1, 0, exp_st(S_MEMWR));

    cyc("lwto_fetch",  LW, 1, 0, exp_fetch(1, 0));
    cyc("lwto_decode", LW, 1, 0, exp_st(S_DECODE));
    cyc("lwto_memadr", LW, 1, 0, exp_st(S_MEMADR));
    for (int i = 0; i < 3; i++) cyc("lwto_stall", LW, 0, 0, exp_st(S_MEMRD));
    cyc("lwto_buserr", LW, 0, 0, with_flags(exp_st(S_MEMRD), 0, 0, 1));

    for (int i = 0; i < 3; i++) cyc("fto_stall", SW, 0, 0, exp_fetch(0, 0));
    cyc("fto_buserr", SW, 0, 0, exp_fetch(0, 1));
    cyc("fto_retry",  SW, 0, 0, exp_fetch(0, 0));
    cyc("fto_done",   SW, 1, 0, exp_fetch(1, 0));

    cyc("swr_decode", SW, 1, 0, exp_st(S_DECODE));
    cyc("swr_memadr", SW, 1, 0, exp_st(S_MEMADR));
    cyc("swr_stall",  SW, 0, 0, exp_st(S_MEMWR));
    reset_n = 1'b0;
    cyc("rst_async",   SW, 0, 0, exp_st(S_RESET));
    cyc("rst_hold2",   SW, 1, 0, exp_st(S_RESET));
    reset_n = 1'b1;
    cyc("rst_release2", LW, 1, 0, exp_st(S_RESET));
    cyc("post_rst_fetch", LW, 1, 0, exp_fetch(1, 0));

    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
